neuron_accumulator_array: RTL and testbench

//  Multi-lane successor to the single 16-bit accumulation register: N_LANES independent signed

---
 rtl/nn_accel_pkg.sv | 15 +
 rtl/neuron_accumulator_array_if.sv | 31 +++
 rtl/sat_add_lane.sv | 22 ++
 rtl/neuron_accumulator_array.sv | 103 ++++++++++
 tb/tb_neuron_accumulator_array.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/nn_accel_pkg.sv
// Shared definitions for the neural accelerator datapath: default lane width,
// saturation limits and the accumulator FSM state encoding.
package nn_accel_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/neuron_accumulator_array_if.sv
// Partial-sum input stream and finished-neuron result stream of the accumulator array.
// master = producer/consumer side, slave = accumulator array.
interface neuron_accumulator_array_if #(
  parameter int DATA_W  = 16,
  parameter int N_LANES = 4,
  parameter int CNT_W   = 10
) ();

  logic                        psum_valid;
  logic                        psum_ready;
  logic [N_LANES*DATA_W-1:0]   psum;
  logic                        neuron_done;
  logic                        relu_en;

  logic                        out_valid;
  logic                        out_ready;
  logic [N_LANES*DATA_W-1:0]   sum_out;
  logic [N_LANES-1:0]          sat_flags;
  logic [CNT_W-1:0]            term_count;

  modport master (
    output psum_valid, psum, neuron_done, relu_en, out_ready,
    input  psum_ready, out_valid, sum_out, sat_flags, term_count
  );

  modport slave (
    input  psum_valid, psum, neuron_done, relu_en, out_ready,
    output psum_ready, out_valid, sum_out, sat_flags, term_count
  );

endinterface

// File: rtl/sat_add_lane.sv
// Signed saturating adder for one neuron lane; sat flags a clamped result.
module sat_add_lane #(
  parameter int DATA_W = nn_accel_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              sat
);

  localparam logic [DATA_W-1:0] LANE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] LANE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0] wide;

  // One extra bit of headroom: the top two bits disagree exactly on overflow.
  assign wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign sat  = wide[DATA_W] ^ wide[DATA_W-1];
  assign sum  = !sat         ? wide[DATA_W-1:0] :
                wide[DATA_W] ? LANE_MIN : LANE_MAX;

endmodule

// File: rtl/neuron_accumulator_array.sv
// N_LANES parallel signed saturating accumulators with a held, optionally
// ReLU-clamped result register released through a valid/ready handshake.
module neuron_accumulator_array
  import nn_accel_pkg::*;
#(
  parameter int DATA_W  = nn_accel_pkg::DATA_W,
  parameter int N_LANES = 4,
  parameter int CNT_W   = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  neuron_accumulator_array_if.slave   bus
);

  state_t                     state;
  logic [DATA_W-1:0]          acc      [N_LANES];
  logic [N_LANES-1:0]         lane_sat;
  logic [CNT_W-1:0]           beat_cnt;

  logic [DATA_W-1:0]          lane_sum  [N_LANES];
  logic [DATA_W-1:0]          lane_pick [N_LANES];
  logic [N_LANES-1:0]         lane_ovf;
  logic [N_LANES*DATA_W-1:0]  final_sum;
  logic [N_LANES-1:0]         final_sat;
  logic [CNT_W-1:0]           cnt_inc;
  logic [CNT_W-1:0]           final_cnt;

  logic                       out_valid_q;
  logic [N_LANES*DATA_W-1:0]  sum_out_q;
  logic [N_LANES-1:0]         sat_flags_q;
  logic [CNT_W-1:0]           term_count_q;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    sat_add_lane #(.DATA_W(DATA_W)) u_add (
      .a   (acc[g]),
      .b   (bus.psum[g*DATA_W +: DATA_W]),
      .sum (lane_sum[g]),
      .sat (lane_ovf[g])
    );

    // A beat arriving with neuron_done belongs to the closing neuron.
    assign lane_pick[g] = bus.psum_valid ? lane_sum[g] : acc[g];
    assign final_sum[g*DATA_W +: DATA_W] =
      (bus.relu_en && lane_pick[g][DATA_W-1]) ? '0 : lane_pick[g];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_inc   = beat_cnt;
    final_sat = lane_sat;
    if (!(&beat_cnt)) cnt_inc = beat_cnt + 1'b1;
    if (bus.psum_valid) final_sat = lane_sat | lane_ovf;
  end

  assign final_cnt = bus.psum_valid ? cnt_inc : beat_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_ACCUM;
      // NOTE: the accumulator array is reset explicitly; a discarded neuron must leave no residue.
      for (int i = 0; i < N_LANES; i++) acc[i] <= '0;
      lane_sat     <= '0;
      beat_cnt     <= '0;
      out_valid_q  <= 1'b0;
      sum_out_q    <= '0;
      sat_flags_q  <= '0;
      term_count_q <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (bus.neuron_done) begin
            sum_out_q    <= final_sum;
            sat_flags_q  <= final_sat;
            term_count_q <= final_cnt;
            out_valid_q  <= 1'b1;
            for (int i = 0; i < N_LANES; i++) acc[i] <= '0;
            lane_sat     <= '0;
            beat_cnt     <= '0;
            state        <= ST_HOLD;
          end else if (bus.psum_valid) begin
            for (int i = 0; i < N_LANES; i++) acc[i] <= lane_sum[i];
            lane_sat     <= lane_sat | lane_ovf;
            beat_cnt     <= cnt_inc;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_ACCUM;
          end
        end
      endcase
    end
  end

  assign bus.psum_ready = (state == ST_ACCUM);
  assign bus.out_valid  = out_valid_q;
  assign bus.sum_out    = sum_out_q;
  assign bus.sat_flags  = sat_flags_q;
  assign bus.term_count = term_count_q;

endmodule

// File: tb/tb_neuron_accumulator_array.sv
// Scoreboard bench for neuron_accumulator_array: a lane model pushes expected
// results on each closing beat; results are popped and compared when presented.
module tb_neuron_accumulator_array;

  localparam int W = 16;
  localparam int N = 4;
  localparam int C = 10;

  typedef struct {
    logic [N*W-1:0] sum;
    logic [N-1:0]   flags;
    logic [C-1:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  neuron_accumulator_array_if #(.DATA_W(W), .N_LANES(N), .CNT_W(C)) bus ();

  neuron_accumulator_array #(.DATA_W(W), .N_LANES(N), .CNT_W(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int     n_err = 0;
  int     n_chk = 0;
  exp_t   sb[$];
  int     m_acc [N];
  bit [N-1:0] m_sat;
  int     m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    m_sat = '0;
    m_cnt = 0;
  endtask

  task automatic model_step(input int v [N], input bit valid, input bit done, input bit relu);
    exp_t e;
    logic signed [W-1:0] t;
    int s;
    if (valid) begin
      for (int i = 0; i < N; i++) begin
        t = v[i][W-1:0];
        s = m_acc[i] + int'(t);
        if (s > 32767)       begin s = 32767;  m_sat[i] = 1'b1; end
        else if (s < -32768) begin s = -32768; m_sat[i] = 1'b1; end
        m_acc[i] = s;
      end
      if (m_cnt < 1023) m_cnt++;
    end
    if (done) begin
      for (int i = 0; i < N; i++) begin
        s = (relu && m_acc[i] < 0) ? 0 : m_acc[i];
        e.sum[i*W +: W] = s[W-1:0];
      end
      e.flags = m_sat;
      e.cnt   = m_cnt[C-1:0];
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic idle_inputs();
    bus.psum_valid  = 1'b0;
    bus.neuron_done = 1'b0;
    bus.relu_en     = 1'b0;
    bus.psum        = '0;
  endtask

  // Drives one cycle starting just after a negedge; returns at the next negedge.
  task automatic send(input int v0, input int v1, input int v2, input int v3,
                      input bit valid, input bit done, input bit relu);
    int v [N];
    bit taken;
    v = '{v0, v1, v2, v3};
    bus.psum_valid  = valid;
    bus.neuron_done = done;
    bus.relu_en     = relu;
    for (int i = 0; i < N; i++) bus.psum[i*W +: W] = v[i][W-1:0];
    taken = bus.psum_ready;
    @(posedge clk);
    if (taken) model_step(v, valid, done, relu);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    sb.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"},  bus.out_valid,  0);
    check({tag, "_sum_out"},    bus.sum_out,    0);
    check({tag, "_sat_flags"},  bus.sat_flags,  0);
    check({tag, "_term_count"}, bus.term_count, 0);
  endtask

  task automatic take_result(input string tag);
    exp_t e;
    for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
    if (!bus.out_valid) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_sum"},   bus.sum_out,    e.sum);
    check({tag, "_flags"}, bus.sat_flags,  e.flags);
    check({tag, "_count"}, bus.term_count, e.cnt);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_released"},   bus.out_valid,  0);
    check({tag, "_ready_back"}, bus.psum_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check_idle("reset");
    check("reset_psum_ready", bus.psum_ready, 1);

    // Basic two-beat neuron; result visible one cycle after the closing edge.
    send(1, 2, 3, 4, 1, 0, 0);
    send(10, 20, 30, 40, 1, 1, 0);
    check("t1_latency", bus.out_valid, 1);
    check("t1_ready_low", bus.psum_ready, 0);
    take_result("t1");

    // Positive and negative saturation with sticky flags on lanes 0 and 1 only.
    send('h7000, 'h9000, 5, -5, 1, 0, 0);
    send('h7000, 'h9000, 5, -5, 1, 0, 0);
    send('hF000, 0, 5, -5, 1, 1, 0);
    take_result("t2");

    // ReLU on and off over lane sums {-5, 7, 0, -32768}.
    send(-5, 3, 0, -20000, 1, 0, 1);
    send(0, 4, 0, -20000, 1, 1, 1);
    take_result("t3_relu");
    send(-5, 3, 0, -20000, 1, 0, 0);
    send(0, 4, 0, -20000, 1, 1, 0);
    take_result("t3_raw");

    // HOLD ignores beats and neuron_done while the consumer stalls.
    send(100, 200, 300, 400, 1, 1, 0);
    repeat (5) begin
      send(9, 9, 9, 9, 1, 1, 0);
      check("t4_ready_low", bus.psum_ready, 0);
      check("t4_valid_held", bus.out_valid, 1);
      if (sb.size() > 0) check("t4_sum_stable", bus.sum_out, sb[0].sum);
    end
    take_result("t4_hold");
    send(1, 1, 1, 1, 1, 0, 0);
    send(2, 2, 2, 2, 1, 1, 0);
    take_result("t4_next");

    // Empty neuron.
    send(0, 0, 0, 0, 0, 1, 0);
    check("t5_latency", bus.out_valid, 1);
    take_result("t5");

    // Reset mid-neuron and mid-HOLD discards everything.
    send(7, 7, 7, 7, 1, 0, 0);
    send(7, 7, 7, 7, 1, 0, 0);
    send(7, 7, 7, 7, 1, 0, 0);
    do_reset();
    @(negedge clk);
    check_idle("t6_mid");
    send(5, 5, 5, 5, 1, 1, 0);
    check("t6_hold_valid", bus.out_valid, 1);
    do_reset();
    @(negedge clk);
    check_idle("t6_hold");
    check("t6_ready", bus.psum_ready, 1);
    send(1, 1, 1, 1, 1, 1, 0);
    take_result("t6_after");
    check("t6_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
